// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared owner/state encodings for the BRAM port arbiter
package bram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  localparam int BURST_W = 4;

endpackage

// File: rtl/rr_burst_sched.sv
// rtl/rr_burst_sched.sv - round-robin scheduler with bounded burst per owner
module rr_burst_sched
  import bram_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req_i,
  input  logic       b_req_i,
  output logic [1:0] gnt_o
);

  localparam logic [BURST_W-1:0] BMAX = BURST_W'(BURST_MAX);

  state_e               state_q;
  owner_e               last_q;
  logic [BURST_W-1:0]   cnt_q;
  logic                 burst_full;

  assign burst_full = (cnt_q >= BMAX);

  // gnt_o is {b, a}; a contested owner yields only once its burst is spent
  always_comb begin
    gnt_o = 2'b00;
    if (a_req_i && b_req_i) begin
      case (state_q)
        ST_OWN_A: gnt_o = burst_full ? 2'b10 : 2'b01;
        ST_OWN_B: gnt_o = burst_full ? 2'b01 : 2'b10;
        default:  gnt_o = (last_q == OWN_A) ? 2'b10 : 2'b01;
      endcase
    end else if (a_req_i) begin
      gnt_o = 2'b01;
    end else if (b_req_i) begin
      gnt_o = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_B;
      cnt_q   <= '0;
    end else if (gnt_o[0]) begin
      last_q  <= OWN_A;
      state_q <= ST_OWN_A;
      if (state_q == ST_OWN_A) cnt_q <= burst_full ? cnt_q : cnt_q + BURST_W'(1);
      else                     cnt_q <= BURST_W'(1);
    end else if (gnt_o[1]) begin
      last_q  <= OWN_B;
      state_q <= ST_OWN_B;
      if (state_q == ST_OWN_B) cnt_q <= burst_full ? cnt_q : cnt_q + BURST_W'(1);
      else                     cnt_q <= BURST_W'(1);
    end else begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter owning one single-port BRAM
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rd_pend_q;
  owner_e            rd_tag_q;
  logic [DATA_W-1:0] a_hold_q;
  logic [DATA_W-1:0] b_hold_q;

  rr_burst_sched #(.BURST_MAX(BURST_MAX)) u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .gnt_o   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Idle cycles replay the last address so the RAM pins never glitch
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr_q;
    mem_din  = din_q;
    if (gnt[0]) begin
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_din  = a_wdata;
    end else if (gnt[1]) begin
      mem_we   = b_we;
      mem_addr = b_addr;
      mem_din  = b_wdata;
    end
  end

  assign a_rvalid = rd_pend_q && (rd_tag_q == OWN_A);
  assign b_rvalid = rd_pend_q && (rd_tag_q == OWN_B);
  assign a_rdata  = a_rvalid ? mem_dout : a_hold_q;
  assign b_rdata  = b_rvalid ? mem_dout : b_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      din_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= OWN_NONE;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
    end else begin
      addr_q    <= mem_addr;
      din_q     <= mem_din;
      rd_pend_q <= (|gnt) && !mem_we;
      rd_tag_q  <= gnt[0] ? OWN_A : (gnt[1] ? OWN_B : OWN_NONE);
      if (a_rvalid) a_hold_q <= mem_dout;
      if (b_rvalid) b_hold_q <= mem_dout;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized and directed checks against a behavioural arbiter model
module tb_bram_port_arbiter;

  localparam int BURST_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first registered RAM macro
  logic [15:0] ram [0:1023];
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_din;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    if (i == 5) return 16'h1234;
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  // Reference model: who owns the port, how long it has held it, who held it last
  logic [15:0] exp_mem [0:1023];
  int          m_own, m_run, m_last, pend, last_g;
  logic [15:0] pend_data, exp_ard, exp_brd;
  logic [9:0]  m_addr;
  logic [1:0]  obs_g;

  function automatic int model_grant();
    if (a_req && b_req) begin
      if (m_own == 0) return (m_last == 1) ? 2 : 1;
      if (m_run < BURST_MAX) return m_own;
      return 3 - m_own;
    end
    if (a_req) return 1;
    if (b_req) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_own = 0; m_run = 0; m_last = 2; pend = 0; last_g = 0;
    exp_ard = '0; exp_brd = '0; m_addr = '0; pend_data = '0;
  endtask

  task automatic step();
    int          g;
    logic        ew;
    logic [9:0]  ea;
    logic [15:0] ed;
    @(negedge clk);
    check_eq("a_rvalid", 32'(a_rvalid), 32'(pend == 1));
    check_eq("b_rvalid", 32'(b_rvalid), 32'(pend == 2));
    if (pend == 1) exp_ard = pend_data;
    if (pend == 2) exp_brd = pend_data;
    check_eq("a_rdata", 32'(a_rdata), 32'(exp_ard));
    check_eq("b_rdata", 32'(b_rdata), 32'(exp_brd));
    g = model_grant();
    obs_g = {b_gnt, a_gnt};
    check_eq("grant", 32'(obs_g), (g == 1) ? 32'd1 : ((g == 2) ? 32'd2 : 32'd0));
    ew = 1'b0; ea = m_addr; ed = '0;
    if (g == 1) begin ew = a_we; ea = a_addr; ed = a_wdata; end
    else if (g == 2) begin ew = b_we; ea = b_addr; ed = b_wdata; end
    check_eq("mem_we", 32'(mem_we), 32'(ew));
    check_eq("mem_addr", 32'(mem_addr), 32'(ea));
    if (ew) check_eq("mem_din", 32'(mem_din), 32'(ed));
    m_addr = ea;
    pend = 0;
    if (g != 0) begin
      if (ew) exp_mem[ea] = ed;
      else begin pend = g; pend_data = exp_mem[ea]; end
    end
    if (g == 0) begin
      if (m_own != 0) m_last = m_own;
      m_own = 0; m_run = 0;
    end else if (g == m_own) begin
      m_run = (m_run < BURST_MAX) ? m_run + 1 : BURST_MAX;
    end else begin
      m_own = g; m_run = 1;
    end
    last_g = g;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    check_eq("rst_a_rdata", 32'(a_rdata), 32'd0);
    check_eq("rst_b_rdata", 32'(b_rdata), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_a(input logic req, input logic we, input logic [9:0] addr, input logic [15:0] d);
    a_req = req; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [9:0] addr, input logic [15:0] d);
    b_req = req; b_we = we; b_addr = addr; b_wdata = d;
  endtask

  initial begin
    string pat;
    rst_n = 1'b0;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 1024; i++) begin
      ram[i] = init_val(i);
      exp_mem[i] = init_val(i);
    end
    model_reset();
    do_reset();

    // single read after reset
    set_a(1'b1, 1'b0, 10'h005, '0);
    step();
    check_eq("t1_gnt", 32'(obs_g), 32'd1);
    set_a(1'b0, 1'b0, 10'h005, '0);
    step();
    check_eq("t1_rdata", 32'(a_rdata), 32'h1234);

    // continuous contention
    do_reset();
    pat = "AAAABBBBAAAA";
    set_a(1'b1, 1'b0, 10'(32), '0);
    set_b(1'b1, 1'b0, 10'(48), '0);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("rr_pattern", 32'(obs_g), (pat[i] == "A") ? 32'd1 : 32'd2);
      if (last_g == 1) a_addr = 10'($urandom_range(0, 31));
      if (last_g == 2) b_addr = 10'($urandom_range(0, 31));
    end
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    step();

    // write then read back
    set_a(1'b1, 1'b1, 10'h00A, 16'hBEEF);
    step();
    set_a(1'b1, 1'b0, 10'h00A, '0);
    step();
    set_a(1'b0, 1'b0, '0, '0);
    step();
    check_eq("t3_rdata", 32'(a_rdata), 32'hBEEF);

    // cross-requester read/write on one address
    do_reset();
    set_a(1'b1, 1'b0, 10'h010, '0);
    set_b(1'b1, 1'b1, 10'h010, 16'h5555);
    step();
    check_eq("t4_first", 32'(obs_g), 32'd1);
    set_a(1'b0, 1'b0, '0, '0);
    step();
    check_eq("t4_a_old", 32'(a_rdata), 32'(init_val(16)));
    set_b(1'b1, 1'b0, 10'h010, '0);
    step();
    set_b(1'b0, 1'b0, '0, '0);
    step();
    check_eq("t4_b_new", 32'(b_rdata), 32'h5555);

    // B alone saturates its burst, then A preempts
    for (int i = 0; i < 10; i++) begin
      set_b(1'b1, 1'b0, 10'($urandom_range(0, 15)), '0);
      step();
    end
    set_a(1'b1, 1'b0, 10'h003, '0);
    step();
    check_eq("burst_preempt", 32'(obs_g), 32'd1);
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    step();

    // reset while a read is in flight
    set_a(1'b1, 1'b0, 10'h007, '0);
    step();
    do_reset();
    set_a(1'b1, 1'b0, 10'h008, '0);
    set_b(1'b1, 1'b0, 10'h009, '0);
    step();
    check_eq("rst_tie", 32'(obs_g), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step();
      if (last_g == 1 || !a_req)
        set_a(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 15)), 16'($urandom));
      if (last_g == 2 || !b_req)
        set_b(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 15)), 16'($urandom));
    end
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
